// File: rtl/div_unit.sv
// rtl/div_unit.sv - iterative RV32M DIV/DIVU/REM/REMU unit writing results to the register file
// Radix-2 restoring divider, one quotient bit per clock, single-cycle fast path for x/0 and overflow.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             SYS_clk,
  input  logic             SYS_reset,
  input  logic             DIV_start,
  input  logic [2:0]       DIV_funct3,
  input  logic [WIDTH-1:0] DIV_rs1_data,
  input  logic [WIDTH-1:0] DIV_rs2_data,
  input  logic [4:0]       DIV_rd,
  input  logic             DIV_flush,
  output logic             DIV_busy,
  output logic             DIV_done,
  output logic [4:0]       REG_write_address,
  output logic             REG_write_enable,
  output logic [WIDTH-1:0] REG_write_value
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]    LAST_COUNT = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ALL_ONES   = '1;
  localparam logic [WIDTH-1:0] MIN_NEG    = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic             is_rem_q, is_rem_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             wen_q, wen_d;
  logic [4:0]       waddr_q, waddr_d;
  logic [WIDTH-1:0] wval_q, wval_d;

  logic             op_signed, op_rem, a_neg, b_neg, div_zero, sgn_ovf;
  logic [WIDTH-1:0] a_abs, b_abs;
  logic [WIDTH:0]   rem_sh, diff;
  logic             step_ok;
  logic [WIDTH-1:0] step_rem, step_quo, fin_rem, fin_quo;

  // Unlisted funct3 codes fall through to unsigned quotient (DIVU).
  assign op_signed = (DIV_funct3 == 3'b100) || (DIV_funct3 == 3'b110);
  assign op_rem    = (DIV_funct3 == 3'b110) || (DIV_funct3 == 3'b111);
  assign a_neg     = op_signed & DIV_rs1_data[WIDTH-1];
  assign b_neg     = op_signed & DIV_rs2_data[WIDTH-1];
  assign a_abs     = a_neg ? ('0 - DIV_rs1_data) : DIV_rs1_data;
  assign b_abs     = b_neg ? ('0 - DIV_rs2_data) : DIV_rs2_data;
  assign div_zero  = (DIV_rs2_data == '0);
  assign sgn_ovf   = op_signed && (DIV_rs1_data == MIN_NEG) && (DIV_rs2_data == ALL_ONES);

  // Partial remainder needs one extra bit: it can reach almost twice the divisor.
  assign rem_sh   = {rem_q, quo_q[WIDTH-1]};
  assign diff     = rem_sh - {1'b0, dvsr_q};
  assign step_ok  = ~diff[WIDTH];
  assign step_rem = step_ok ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
  assign step_quo = {quo_q[WIDTH-2:0], step_ok};
  assign fin_quo  = neg_quo_q ? ('0 - step_quo) : step_quo;
  assign fin_rem  = neg_rem_q ? ('0 - step_rem) : step_rem;

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    dvsr_d    = dvsr_q;
    is_rem_d  = is_rem_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    wen_d     = 1'b0;
    waddr_d   = waddr_q;
    wval_d    = wval_q;
    case (state_q)
      IDLE: begin
        if (DIV_start && !DIV_flush) begin
          busy_d   = 1'b1;
          is_rem_d = op_rem;
          waddr_d  = DIV_rd;
          count_d  = '0;
          if (div_zero || sgn_ovf) begin
            state_d = DONE;
            done_d  = 1'b1;
            wen_d   = (DIV_rd != 5'd0);
            if (div_zero) wval_d = op_rem ? DIV_rs1_data : ALL_ONES;
            else          wval_d = op_rem ? '0 : MIN_NEG;
          end else begin
            state_d   = CALC;
            quo_d     = a_abs;
            rem_d     = '0;
            dvsr_d    = b_abs;
            neg_quo_d = a_neg ^ b_neg;
            neg_rem_d = a_neg;
          end
        end
      end
      CALC: begin
        if (DIV_flush) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          quo_d   = step_quo;
          rem_d   = step_rem;
          count_d = count_q + 1'b1;
          if (count_q == LAST_COUNT) begin
            state_d = DONE;
            done_d  = 1'b1;
            wen_d   = (waddr_q != 5'd0);
            wval_d  = is_rem_q ? fin_rem : fin_quo;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge SYS_clk) begin
    if (SYS_reset) begin
      state_q   <= IDLE;
      count_q   <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      dvsr_q    <= '0;
      is_rem_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      wen_q     <= 1'b0;
      waddr_q   <= '0;
      wval_q    <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      dvsr_q    <= dvsr_d;
      is_rem_q  <= is_rem_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      wen_q     <= wen_d;
      waddr_q   <= waddr_d;
      wval_q    <= wval_d;
    end
  end

  assign DIV_busy          = busy_q;
  assign DIV_done          = done_q;
  assign REG_write_enable  = wen_q;
  assign REG_write_address = waddr_q;
  assign REG_write_value   = wval_q;

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - directed and randomized self-checking bench for div_unit
module tb_div_unit;

  logic        SYS_clk = 1'b0;
  logic        SYS_reset;
  logic        DIV_start;
  logic [2:0]  DIV_funct3;
  logic [31:0] DIV_rs1_data;
  logic [31:0] DIV_rs2_data;
  logic [4:0]  DIV_rd;
  logic        DIV_flush;
  logic        DIV_busy;
  logic        DIV_done;
  logic [4:0]  REG_write_address;
  logic        REG_write_enable;
  logic [31:0] REG_write_value;

  int n_assert = 0;
  int n_fail = 0;
  int wen_pulses = 0;
  int done_pulses = 0;

  div_unit #(.WIDTH(32)) dut (
    .SYS_clk(SYS_clk),
    .SYS_reset(SYS_reset),
    .DIV_start(DIV_start),
    .DIV_funct3(DIV_funct3),
    .DIV_rs1_data(DIV_rs1_data),
    .DIV_rs2_data(DIV_rs2_data),
    .DIV_rd(DIV_rd),
    .DIV_flush(DIV_flush),
    .DIV_busy(DIV_busy),
    .DIV_done(DIV_done),
    .REG_write_address(REG_write_address),
    .REG_write_enable(REG_write_enable),
    .REG_write_value(REG_write_value)
  );

  always #5 SYS_clk = ~SYS_clk;

  always @(negedge SYS_clk) begin
    if (REG_write_enable) wen_pulses++;
    if (DIV_done) done_pulses++;
  end

  task automatic tick();
    @(posedge SYS_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] golden(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb, qs, rs;
    logic ovf;
    sa  = a;
    sb  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    if (f3 == 3'b100 || f3 == 3'b110) begin
      if (b == 32'd0) return (f3 == 3'b110) ? a : 32'hFFFF_FFFF;
      if (ovf) return (f3 == 3'b110) ? 32'd0 : a;
      qs = sa / sb;
      rs = sa % sb;
      if (f3 == 3'b110) return rs;
      return qs;
    end
    if (b == 32'd0) return (f3 == 3'b111) ? a : 32'hFFFF_FFFF;
    if (f3 == 3'b111) return a % b;
    return a / b;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // One operation: accept, scramble inputs, wait (bounded) for done, step back to idle.
  task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, output logic [31:0] val, output int lat,
                       output logic wen, output logic [4:0] addr);
    DIV_funct3   = f3;
    DIV_rs1_data = a;
    DIV_rs2_data = b;
    DIV_rd       = rd;
    DIV_start    = 1'b1;
    tick();
    DIV_start    = 1'b0;
    DIV_rs1_data = $urandom;
    DIV_rs2_data = $urandom;
    DIV_funct3   = 3'($urandom);
    DIV_rd       = 5'($urandom);
    check("busy_after_accept", 32'(DIV_busy), 32'd1);
    lat = 0;
    while (!DIV_done && lat < 100) begin
      tick();
      lat++;
    end
    val  = REG_write_value;
    wen  = REG_write_enable;
    addr = REG_write_address;
    tick();
    check("idle_after_done", {30'd0, DIV_busy, DIV_done}, 32'd0);
  endtask

  initial begin
    logic [31:0] val, a, b, exp_v;
    logic [2:0]  f3;
    logic [4:0]  rd, addr;
    logic        wen, special;
    int          lat, w0, d0, exp_pulses;

    SYS_reset    = 1'b1;
    DIV_start    = 1'b0;
    DIV_flush    = 1'b0;
    DIV_funct3   = 3'b101;
    DIV_rs1_data = 32'd100;
    DIV_rs2_data = 32'd7;
    DIV_rd       = 5'd5;
    tick();
    DIV_start = 1'b1;
    tick();
    check("reset_busy", 32'(DIV_busy), 32'd0);
    check("reset_done", 32'(DIV_done), 32'd0);
    check("reset_wen", 32'(REG_write_enable), 32'd0);
    check("reset_addr", 32'(REG_write_address), 32'd0);
    check("reset_value", REG_write_value, 32'd0);
    DIV_start = 1'b0;
    SYS_reset = 1'b0;
    tick();

    w0 = wen_pulses;
    d0 = done_pulses;
    do_op(3'b101, 32'd100, 32'd7, 5'd5, val, lat, wen, addr);
    check("divu_100_7_value", val, 32'd14);
    check("divu_100_7_latency", lat, 32'd32);
    check("divu_100_7_wen", 32'(wen), 32'd1);
    check("divu_100_7_addr", 32'(addr), 32'd5);
    check("divu_100_7_wen_pulses", wen_pulses - w0, 32'd1);
    check("divu_100_7_done_pulses", done_pulses - d0, 32'd1);

    do_op(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd3, val, lat, wen, addr);
    check("div_m7_2", val, 32'hFFFF_FFFD);
    do_op(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd3, val, lat, wen, addr);
    check("rem_m7_2", val, 32'hFFFF_FFFF);
    check("rem_m7_2_addr", 32'(addr), 32'd3);
    do_op(3'b111, 32'hFFFF_FFFF, 32'd16, 5'd3, val, lat, wen, addr);
    check("remu_max_16", val, 32'h0000_000F);

    do_op(3'b100, 32'd123, 32'd0, 5'd2, val, lat, wen, addr);
    check("div_by_zero", val, 32'hFFFF_FFFF);
    check("div_by_zero_latency", lat, 32'd0);
    do_op(3'b110, 32'd123, 32'd0, 5'd2, val, lat, wen, addr);
    check("rem_by_zero", val, 32'd123);
    do_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd2, val, lat, wen, addr);
    check("div_overflow", val, 32'h8000_0000);
    check("div_overflow_latency", lat, 32'd0);
    do_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd2, val, lat, wen, addr);
    check("rem_overflow", val, 32'd0);
    do_op(3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 5'd2, val, lat, wen, addr);
    check("divu_min_max", val, 32'd0);
    check("divu_min_max_latency", lat, 32'd32);

    w0 = wen_pulses;
    d0 = done_pulses;
    do_op(3'b101, 32'd50, 32'd5, 5'd0, val, lat, wen, addr);
    check("rd0_value", val, 32'd10);
    check("rd0_wen_pulses", wen_pulses - w0, 32'd0);
    check("rd0_done_pulses", done_pulses - d0, 32'd1);

    // Start held high through CALC and DONE must not restart or re-sample.
    DIV_funct3   = 3'b101;
    DIV_rs1_data = 32'd1000;
    DIV_rs2_data = 32'd10;
    DIV_rd       = 5'd7;
    DIV_start    = 1'b1;
    tick();
    DIV_rs1_data = 32'd77;
    DIV_rs2_data = 32'd3;
    lat = 0;
    while (!DIV_done && lat < 100) begin
      tick();
      lat++;
    end
    check("hold_start_value", REG_write_value, 32'd100);
    check("hold_start_latency", lat, 32'd32);
    tick();
    check("hold_start_idle", 32'(DIV_busy), 32'd0);
    DIV_start = 1'b0;
    tick();
    check("hold_start_no_requeue", 32'(DIV_busy), 32'd0);

    w0 = wen_pulses;
    DIV_funct3   = 3'b101;
    DIV_rs1_data = 32'd1000;
    DIV_rs2_data = 32'd3;
    DIV_rd       = 5'd4;
    DIV_start    = 1'b1;
    tick();
    DIV_start = 1'b0;
    repeat (9) tick();
    SYS_reset = 1'b1;
    tick();
    check("midreset_busy", 32'(DIV_busy), 32'd0);
    check("midreset_addr", 32'(REG_write_address), 32'd0);
    SYS_reset = 1'b0;
    repeat (30) tick();
    check("midreset_no_write", wen_pulses - w0, 32'd0);
    check("midreset_still_idle", 32'(DIV_busy), 32'd0);

    DIV_rd    = 5'd9;
    DIV_start = 1'b1;
    tick();
    DIV_start = 1'b0;
    repeat (19) tick();
    DIV_flush = 1'b1;
    DIV_start = 1'b1;
    tick();
    check("flush_calc_busy", 32'(DIV_busy), 32'd0);
    tick();
    check("flush_idle_blocks_start", 32'(DIV_busy), 32'd0);
    DIV_flush = 1'b0;
    DIV_start = 1'b0;
    repeat (3) tick();

    DIV_start = 1'b1;
    tick();
    DIV_start = 1'b0;
    repeat (31) tick();
    DIV_flush = 1'b1;
    tick();
    check("flush_last_edge_done", {30'd0, DIV_busy, DIV_done}, 32'd0);
    DIV_flush = 1'b0;
    tick();
    check("flush_no_write", wen_pulses - w0, 32'd0);

    do_op(3'b100, 32'd1000, 32'hFFFF_FFF9, 5'd9, val, lat, wen, addr);
    check("after_flush_value", val, 32'hFFFF_FF72);
    check("after_flush_wen", 32'(wen), 32'd1);

    w0 = wen_pulses;
    exp_pulses = 0;
    for (int i = 0; i < 2000; i++) begin
      f3 = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(4, 7));
      a  = pick();
      b  = pick();
      rd = 5'($urandom);
      exp_v   = golden(f3, a, b);
      special = (b == 32'd0) ||
                ((f3 == 3'b100 || f3 == 3'b110) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
      if (rd != 5'd0) exp_pulses++;
      do_op(f3, a, b, rd, val, lat, wen, addr);
      check($sformatf("rand%0d_f%0d_%08h_%08h", i, f3, a, b), val, exp_v);
      check("rand_latency", lat, special ? 32'd0 : 32'd32);
      check("rand_wen", 32'(wen), 32'(rd != 5'd0));
    end
    check("rand_wen_pulses", wen_pulses - w0, exp_pulses);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
